// File: rtl/gbpt_ghr.sv
// Speculative global-history register with a circular FIFO of per-branch
// checkpoints, restored on restart and drained in order to the GBPT update path.
module gbpt_ghr #(
  parameter int GH_LENGTH        = 12,
  parameter int CKPT_ENTRIES     = 8,
  parameter int LOG_CKPT_ENTRIES = 3
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        alloc_valid,
  input  logic                        alloc_taken,
  output logic                        alloc_ready,
  output logic [LOG_CKPT_ENTRIES-1:0] alloc_index,
  output logic [GH_LENGTH-1:0]        GH_RESP,
  input  logic                        restart_valid,
  input  logic [LOG_CKPT_ENTRIES-1:0] restart_index,
  input  logic                        restart_taken,
  input  logic                        free_valid,
  output logic [GH_LENGTH-1:0]        free_GH,
  output logic [LOG_CKPT_ENTRIES-1:0] free_index,
  output logic [LOG_CKPT_ENTRIES:0]   ckpt_count
);

  localparam int PW = LOG_CKPT_ENTRIES + 1;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [PW-1:0]                 head, tail, count;
  logic [GH_LENGTH-1:0]          gh;
  logic [GH_LENGTH-1:0]          ckpt [CKPT_ENTRIES];
  logic [LOG_CKPT_ENTRIES-1:0]   head_idx, tail_idx, restart_offset;
  logic [PW-1:0]                 restart_tail;
  logic                          empty, full;
  logic                          restart_hit, alloc_fire, free_fire;

  assign head_idx = head[LOG_CKPT_ENTRIES-1:0];
  assign tail_idx = tail[LOG_CKPT_ENTRIES-1:0];
  assign count    = tail - head;
  assign empty    = (head == tail);
  assign full     = (head_idx == tail_idx) && (head[PW-1] != tail[PW-1]);

  // Distance of the restart target from the head; it is live only if that
  // distance is below the live count, which handles the circular range.
  assign restart_offset = restart_index - head_idx;
  assign restart_hit    = restart_valid && ({1'b0, restart_offset} < count);
  assign restart_tail   = head + {1'b0, restart_offset} + PW'(1);

  // Raw restart_valid blocks allocation even when the restart misses.
  assign alloc_fire = alloc_valid && !full && !restart_valid;
  assign free_fire  = free_valid && !empty;

  assign alloc_ready = !full;
  assign alloc_index = tail_idx;
  assign GH_RESP     = gh;
  assign free_GH     = ckpt[head_idx];
  assign free_index  = head_idx;
  assign ckpt_count  = count;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      gh   <= '0;
      head <= '0;
      tail <= '0;
      // NOTE: the checkpoint array is flops and is cleared on reset so free_GH
      // reads a defined value before any branch is allocated.
      for (int i = 0; i < CKPT_ENTRIES; i++) ckpt[i] <= '0;
    end else begin
      if (free_fire) head <= head + PW'(1);
      if (restart_hit) begin
        gh   <= {ckpt[restart_index][GH_LENGTH-2:0], restart_taken};
        tail <= restart_tail;
      end else if (alloc_fire) begin
        ckpt[tail_idx] <= gh;
        tail           <= tail + PW'(1);
        gh             <= {gh[GH_LENGTH-2:0], alloc_taken};
      end
    end
  end

endmodule

// File: tb/tb_gbpt_ghr.sv
// Directed self-checking bench for gbpt_ghr: alloc, full, restart, wrap and reset.
module tb_gbpt_ghr;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        alloc_valid, alloc_taken, alloc_ready;
  logic [2:0]  alloc_index;
  logic [11:0] GH_RESP;
  logic        restart_valid, restart_taken;
  logic [2:0]  restart_index;
  logic        free_valid;
  logic [11:0] free_GH;
  logic [2:0]  free_index;
  logic [3:0]  ckpt_count;

  int checks = 0;
  int errors = 0;

  gbpt_ghr dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .alloc_valid   (alloc_valid),
    .alloc_taken   (alloc_taken),
    .alloc_ready   (alloc_ready),
    .alloc_index   (alloc_index),
    .GH_RESP       (GH_RESP),
    .restart_valid (restart_valid),
    .restart_index (restart_index),
    .restart_taken (restart_taken),
    .free_valid    (free_valid),
    .free_GH       (free_GH),
    .free_index    (free_index),
    .ckpt_count    (ckpt_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    alloc_valid   = 1'b0;
    alloc_taken   = 1'b0;
    restart_valid = 1'b0;
    restart_index = 3'd0;
    restart_taken = 1'b0;
    free_valid    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
  endtask

  task automatic alloc(input logic taken);
    idle();
    alloc_valid = 1'b1;
    alloc_taken = taken;
    tick();
    idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".gh"},     32'(GH_RESP),     32'h000);
    check({tag, ".ready"},  32'(alloc_ready), 32'd1);
    check({tag, ".aidx"},   32'(alloc_index), 32'd0);
    check({tag, ".fgh"},    32'(free_GH),     32'h000);
    check({tag, ".fidx"},   32'(free_index),  32'd0);
    check({tag, ".count"},  32'(ckpt_count),  32'd0);
  endtask

  initial begin
    logic [11:0] gh_m;
    logic [11:0] pushed [$];
    logic [10:0] pattern;

    idle();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
    check_reset_outputs("reset");

    // Taken, taken, not-taken.
    alloc(1'b1); check("ttn.gh1", 32'(GH_RESP), 32'h001);
    alloc(1'b1); check("ttn.gh2", 32'(GH_RESP), 32'h003);
    alloc(1'b0); check("ttn.gh3", 32'(GH_RESP), 32'h006);
    check("ttn.count", 32'(ckpt_count), 32'd3);
    check("ttn.ckpt0", 32'(free_GH), 32'h000);
    free_valid = 1'b1; tick();
    check("ttn.ckpt1", 32'(free_GH), 32'h001);
    tick();
    check("ttn.ckpt2", 32'(free_GH), 32'h003);
    tick();
    idle();
    check("ttn.drained", 32'(ckpt_count), 32'd0);

    // Fill to capacity, then try to overflow.
    do_reset();
    for (int i = 0; i < 8; i++) alloc(1'b1);
    check("full.count", 32'(ckpt_count),  32'd8);
    check("full.ready", 32'(alloc_ready), 32'd0);
    check("full.gh",    32'(GH_RESP),     32'h0FF);
    alloc(1'b0);
    check("full.drop_gh",    32'(GH_RESP),     32'h0FF);
    check("full.drop_count", 32'(ckpt_count),  32'd8);
    check("full.drop_aidx",  32'(alloc_index), 32'd0);
    alloc_valid = 1'b1; alloc_taken = 1'b0; free_valid = 1'b1;
    tick(); idle();
    check("full.af_count", 32'(ckpt_count), 32'd7);
    check("full.af_gh",    32'(GH_RESP),    32'h0FF);
    check("full.af_fidx",  32'(free_index), 32'd1);
    check("full.af_ready", 32'(alloc_ready), 32'd1);

    // Restart: ckpt 0..4 = 000,001,003,007,00F and GH = 01F.
    do_reset();
    for (int i = 0; i < 5; i++) alloc(1'b1);
    check("rs.gh0", 32'(GH_RESP), 32'h01F);
    restart_valid = 1'b1; restart_index = 3'd6; restart_taken = 1'b1;
    tick(); idle();
    check("rs.out_gh",    32'(GH_RESP),     32'h01F);
    check("rs.out_count", 32'(ckpt_count),  32'd5);
    check("rs.out_aidx",  32'(alloc_index), 32'd5);
    restart_valid = 1'b1; restart_index = 3'd2; restart_taken = 1'b0;
    tick(); idle();
    check("rs.in_gh",    32'(GH_RESP),     32'h006);
    check("rs.in_count", 32'(ckpt_count),  32'd3);
    check("rs.in_aidx",  32'(alloc_index), 32'd3);
    // Restart to ckpt1 (001) taken, with a competing alloc that must be dropped.
    restart_valid = 1'b1; restart_index = 3'd1; restart_taken = 1'b1;
    alloc_valid = 1'b1; alloc_taken = 1'b0;
    tick(); idle();
    check("rsa.gh",    32'(GH_RESP),     32'h003);
    check("rsa.aidx",  32'(alloc_index), 32'd2);
    check("rsa.count", 32'(ckpt_count),  32'd2);
    // Restart to the head together with a free empties the buffer.
    restart_valid = 1'b1; restart_index = 3'd0; restart_taken = 1'b0;
    free_valid = 1'b1;
    tick(); idle();
    check("rsf.gh",    32'(GH_RESP),     32'h000);
    check("rsf.count", 32'(ckpt_count),  32'd0);
    check("rsf.fidx",  32'(free_index),  32'd1);
    check("rsf.aidx",  32'(alloc_index), 32'd1);
    free_valid = 1'b1;
    tick(); idle();
    check("empty_free.count", 32'(ckpt_count), 32'd0);
    check("empty_free.fidx",  32'(free_index), 32'd1);

    // Wrap: 11 branches through the FIFO, head and tail cross index 7.
    do_reset();
    gh_m = 12'h000;
    pattern = 11'b101_1001_1101;
    for (int i = 0; i <= 11; i++) begin
      idle();
      if (i < 11) begin
        alloc_valid = 1'b1;
        alloc_taken = pattern[i];
      end
      if (i > 0) begin
        free_valid = 1'b1;
        check($sformatf("wrap.fgh%0d", i - 1), 32'(free_GH), 32'(pushed[0]));
        check($sformatf("wrap.fidx%0d", i - 1), 32'(free_index), 32'((i - 1) % 8));
        void'(pushed.pop_front());
      end
      if (i < 11) begin
        pushed.push_back(gh_m);
        gh_m = {gh_m[10:0], pattern[i]};
      end
      tick();
    end
    idle();
    check("wrap.gh",    32'(GH_RESP),    32'(gh_m));
    check("wrap.count", 32'(ckpt_count), 32'd0);
    check("wrap.fidx",  32'(free_index), 32'd3);

    // Reset mid-operation overrides a pending restart.
    do_reset();
    for (int i = 0; i < 5; i++) alloc(1'b1);
    check("mid.count_pre", 32'(ckpt_count), 32'd5);
    restart_valid = 1'b1; restart_index = 3'd2; restart_taken = 1'b1;
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    idle();
    check_reset_outputs("mid");
    tick();
    check_reset_outputs("mid_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
